// File: rtl/cpu_sequencer.sv
// Eight-phase instruction sequencer for the accumulator CPU.
// Optional single-step gating: define CPU_SEQ_STEP_EN to add the step input.
module cpu_sequencer #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef CPU_SEQ_STEP_EN
    input  logic                 step,
`endif
    input  logic [2:0]           opcode,
    input  logic                 zero,
    output logic                 sel,
    output logic                 rd,
    output logic                 ld_ir,
    output logic                 inc_pc,
    output logic                 ld_pc,
    output logic                 ld_ac,
    output logic                 wr,
    output logic                 data_e,
    output logic                 halt,
    output logic [2:0]           phase,
    output logic [CNT_WIDTH-1:0] instr_count
);

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    phase_t state;
    logic   halted;
    logic   go;
    logic   aluop;

`ifdef CPU_SEQ_STEP_EN
    assign go = step;
`else
    assign go = 1'b1;
`endif

    assign aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                   (opcode == OP_XOR) || (opcode == OP_LDA);

    // Halted parks the ring at OP_ADDR, so phase naturally reads 4.
    assign phase = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= INST_ADDR;
            halted      <= 1'b0;
            instr_count <= '0;
        end else if (!halted) begin
            unique case (state)
                INST_ADDR:  if (go) state <= INST_FETCH;
                INST_FETCH: state <= INST_LOAD;
                INST_LOAD:  state <= IDLE;
                IDLE:       state <= OP_ADDR;
                OP_ADDR: begin
                    if (opcode == OP_HLT) begin
                        halted      <= 1'b1;
                        instr_count <= instr_count + CNT_WIDTH'(1);
                    end else begin
                        state <= OP_FETCH;
                    end
                end
                OP_FETCH:   state <= ALU_OP;
                ALU_OP:     state <= STORE;
                STORE: begin
                    state       <= INST_ADDR;
                    instr_count <= instr_count + CNT_WIDTH'(1);
                end
            endcase
        end
    end

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        if (halted) begin
            halt = 1'b1;
        end else begin
            unique case (state)
                INST_ADDR: sel = 1'b1;
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = (opcode == OP_HLT);
                end
                OP_FETCH: rd = aluop;
                ALU_OP: begin
                    rd     = aluop;
                    inc_pc = (opcode == OP_SKZ) && zero;
                    ld_pc  = (opcode == OP_JMP);
                    data_e = (opcode == OP_STO);
                end
                STORE: begin
                    rd     = aluop;
                    ld_ac  = aluop;
                    ld_pc  = (opcode == OP_JMP);
                    wr     = (opcode == OP_STO);
                    data_e = (opcode == OP_STO);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: vector table, corner sequences,
// and randomized traffic against a phase-list reference model.
module tb_cpu_sequencer;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [2:0]    opcode = 3'd2;
    logic          zero = 1'b0;
`ifdef CPU_SEQ_STEP_EN
    logic          step = 1'b1;
`endif
    logic          sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
    logic [2:0]    phase;
    logic [CW-1:0] instr_count;

    cpu_sequencer #(.CNT_WIDTH(CW)) dut (
        .clk(clk),
        .rst(rst),
`ifdef CPU_SEQ_STEP_EN
        .step(step),
`endif
        .opcode(opcode),
        .zero(zero),
        .sel(sel),
        .rd(rd),
        .ld_ir(ld_ir),
        .inc_pc(inc_pc),
        .ld_pc(ld_pc),
        .ld_ac(ld_ac),
        .wr(wr),
        .data_e(data_e),
        .halt(halt),
        .phase(phase),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,halt}
    wire [8:0] outs = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};

    int checks = 0;
    int failures = 0;

    // reference model state
    int m_ph = 0;
    bit m_hlt = 1'b0;
    int m_cnt = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] ref_out(int p, bit h, logic [2:0] op, logic z);
        bit alu = (op >= 3'd2 && op <= 3'd5);
        bit s = 0, r = 0, li = 0, ip = 0, lp = 0, la = 0, w = 0, de = 0, hl = 0;
        if (h) return 9'b000000001;
        if (p <= 3) s = 1;
        if (p >= 1 && p <= 3) r = 1;
        if (p == 2 || p == 3) li = 1;
        if (p == 4) begin
            ip = 1;
            hl = (op == 3'd0);
        end
        if (p >= 5) r = alu;
        if (p == 6) ip = (op == 3'd1) && z;
        if (p >= 6) begin
            lp = (op == 3'd7);
            de = (op == 3'd6);
        end
        if (p == 7) begin
            la = alu;
            w  = (op == 3'd6);
        end
        return {s, r, li, ip, lp, la, w, de, hl};
    endfunction

    task automatic model_adv(input bit r, input logic [2:0] op, input bit st);
        if (r) begin
            m_ph = 0;
            m_hlt = 0;
            m_cnt = 0;
        end else if (!m_hlt) begin
            if (m_ph == 4 && op == 3'd0) begin
                m_hlt = 1;
                m_cnt = (m_cnt + 1) % (1 << CW);
            end else if (m_ph == 0 && !st) begin
                m_ph = 0;
            end else begin
                if (m_ph == 7) m_cnt = (m_cnt + 1) % (1 << CW);
                m_ph = (m_ph + 1) % 8;
            end
        end
    endtask

    task automatic tick();
        bit r = rst;
        logic [2:0] op = opcode;
        bit st;
`ifdef CPU_SEQ_STEP_EN
        st = step;
`else
        st = 1'b1;
`endif
        @(posedge clk);
        model_adv(r, op, st);
        #2;
    endtask

    task automatic chk_model(input string tag);
        #1;
        chk({tag, ".outs"}, int'(outs), int'(ref_out(m_ph, m_hlt, opcode, zero)));
        chk({tag, ".phase"}, int'(phase), m_hlt ? 4 : m_ph);
        chk({tag, ".count"}, int'(instr_count), m_cnt);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic run_to(input int ph);
        int n = 0;
        while (int'(phase) != ph && n < 16) begin
            tick();
            n++;
        end
        if (int'(phase) != ph) chk("run_to", int'(phase), ph);
    endtask

    typedef struct {
        logic [2:0] op;
        logic       z;
        int         ph;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vecs = '{
            '{3'd2, 1'b0, 0, 9'b100000000},
            '{3'd2, 1'b0, 1, 9'b110000000},
            '{3'd2, 1'b0, 2, 9'b111000000},
            '{3'd2, 1'b0, 3, 9'b111000000},
            '{3'd2, 1'b0, 4, 9'b000100000},
            '{3'd2, 1'b0, 5, 9'b010000000},
            '{3'd2, 1'b0, 6, 9'b010000000},
            '{3'd2, 1'b0, 7, 9'b010001000},
            '{3'd1, 1'b1, 4, 9'b000100000},
            '{3'd1, 1'b1, 6, 9'b000100000},
            '{3'd1, 1'b1, 7, 9'b000000000},
            '{3'd1, 1'b0, 6, 9'b000000000},
            '{3'd6, 1'b0, 5, 9'b000000000},
            '{3'd6, 1'b0, 6, 9'b000000010},
            '{3'd6, 1'b0, 7, 9'b000000110},
            '{3'd7, 1'b0, 4, 9'b000100000},
            '{3'd7, 1'b0, 6, 9'b000010000},
            '{3'd7, 1'b0, 7, 9'b000010000},
            '{3'd0, 1'b0, 4, 9'b000100001}
        };

        // reset state
        do_reset();
        #1;
        chk("reset.phase", int'(phase), 0);
        chk("reset.outs", int'(outs), 9'b100000000);
        chk("reset.halt", int'(halt), 0);
        chk("reset.count", int'(instr_count), 0);

        // per-phase decode vectors
        foreach (vecs[i]) begin
            opcode = vecs[i].op;
            zero = vecs[i].z;
            do_reset();
            run_to(vecs[i].ph);
            #1;
            chk($sformatf("vec%0d", i), int'(outs), int'(vecs[i].exp));
        end

        // ADD free-run: three instructions in 24 clocks
        opcode = 3'd2;
        zero = 1'b0;
        do_reset();
        repeat (24) tick();
        chk("add24.count", int'(instr_count), 3);
        chk("add24.phase", int'(phase), 0);
        repeat (104) tick();
        chk("wrap.count", int'(instr_count), 0);
        repeat (8) tick();
        chk("wrap1.count", int'(instr_count), 1);

        // HLT: halt, freeze, then reset out
        opcode = 3'd0;
        do_reset();
        run_to(4);
        tick();
        chk("hlt.count", int'(instr_count), 1);
        for (int i = 0; i < 22; i++) begin
            chk("hlt.outs", int'(outs), 9'b000000001);
            chk("hlt.phase", int'(phase), 4);
            tick();
        end
        chk("hlt.frozen", int'(instr_count), 1);
        do_reset();
        #1;
        chk("hlt.rst.phase", int'(phase), 0);
        chk("hlt.rst.halt", int'(halt), 0);
        chk("hlt.rst.count", int'(instr_count), 0);

        // reset mid-instruction during STO
        opcode = 3'd6;
        do_reset();
        run_to(6);
        do_reset();
        #1;
        chk("sto.rst.phase", int'(phase), 0);
        chk("sto.rst.outs", int'(outs), 9'b100000000);
`ifdef CPU_SEQ_STEP_EN
        step = 1'b0;
        repeat (5) begin
            tick();
            chk("step.hold.phase", int'(phase), 0);
            chk("step.hold.outs", int'(outs), 9'b100000000);
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        for (int i = 1; i < 8; i++) begin
            chk("step.pass.phase", int'(phase), i);
            tick();
        end
        repeat (3) begin
            chk("step.after.phase", int'(phase), 0);
            tick();
        end
        chk("step.count", int'(instr_count), 1);
        step = 1'b1;
`else
        tick();
        chk("sto.rst.next", int'(phase), 1);
`endif

        // randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            zero = 1'($urandom);
            if (!m_hlt && m_ph <= 2 && $urandom_range(0, 3) == 0)
                opcode = 3'($urandom);
`ifdef CPU_SEQ_STEP_EN
            step = ($urandom_range(0, 2) != 0);
`endif
            chk_model("rand");
            tick();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Eight-phase instruction sequencer for the accumulator CPU. It sits directly upstream of the ALU.
- Steps a fixed phase ring and decodes the instruction-register opcode into per-phase control strobes: memory select and read/write, IR/PC/AC loads, PC increment, and data-bus enable.
- Consumes the ALU's accumulator-zero flag to resolve SKZ.
- Opcode encoding is shared with the ALU: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.

Parameters:
- CNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- opcode  input  3  current IR opcode; stable from IDLE phase onward.
- zero  input  1  accumulator-is-zero flag from the ALU.
- sel  output  1  memory address mux: 1 = PC, 0 = IR operand.
- rd  output  1  memory read strobe.
- ld_ir  output  1  instruction register load.
- inc_pc  output  1  program counter increment.
- ld_pc  output  1  program counter load (jump).
- ld_ac  output  1  accumulator load from ALU.
- wr  output  1  memory write strobe.
- data_e  output  1  drive accumulator onto data bus.
- halt  output  1  CPU halted.
- phase  output  3  current phase, 0..7 per the list below.
- instr_count  output  CNT_WIDTH  instructions retired since reset.

Behaviour:
- Phases, in ring order, with their encodings: INST_ADDR=0, INST_FETCH=1, INST_LOAD=2, IDLE=3, OP_ADDR=4, OP_FETCH=5, ALU_OP=6, STORE=7.
- Advance one phase per clock; STORE returns to INST_ADDR.
- There is a separate HALTED state. It is held in a flag bit, and phase reads 4 while halted.
- Reset (rst=1 at a clock edge):
  - phase goes to INST_ADDR, the halted flag clears, instr_count goes to 0.
  - Decoded outputs after reset: sel=1, all other strobes 0, halt=0.
  - rst overrides everything, including the halted state and mid-instruction phases. There is no completion of a partial instruction.
- Control strobes are a combinational decode of the registered phase, opcode and zero. Signals not listed for a phase are 0. "ALUOP" means opcode is ADD, AND, XOR or LDA.
  - INST_ADDR: sel=1.
  - INST_FETCH: sel=1, rd=1.
  - INST_LOAD: sel=1, rd=1, ld_ir=1.
  - IDLE: sel=1, rd=1, ld_ir=1.
  - OP_ADDR: inc_pc=1; halt=1 if opcode==HLT.
  - OP_FETCH: rd=ALUOP.
  - ALU_OP: rd=ALUOP; inc_pc=(opcode==SKZ && zero); ld_pc=(opcode==JMP); data_e=(opcode==STO).
  - STORE: rd=ALUOP; ld_ac=ALUOP; ld_pc=(opcode==JMP); wr=(opcode==STO); data_e=(opcode==STO).
- HLT handling:
  - At the OP_ADDR clock edge with opcode==HLT, the sequencer enters HALTED instead of OP_FETCH.
  - While HALTED: halt=1, all other strobes 0, the sequencer does not advance, and instr_count is frozen.
  - Only rst exits HALTED.
  - HLT counts as retired: instr_count increments on entry to HALTED.
- instr_count increments by 1 on each STORE→INST_ADDR transition. It wraps modulo 2^CNT_WIDTH with no saturation.
- Opcode changes in phases other than INST_ADDR..IDLE are a protocol violation. The decode tracks the opcode input combinationally; no latching is required.
- zero is only consulted in ALU_OP.

Optional Feature:
- Macro: CPU_SEQ_STEP_EN.
- When defined:
  - Adds input `step` (1 bit).
  - The sequencer holds in INST_ADDR, with sel=1 and everything else 0, until it samples step=1 at a clock edge. Then it advances to INST_FETCH and runs exactly one instruction.
  - If step is held high, instructions run back-to-back.
  - Directly after reset, the sequencer also waits for step.
- When undefined: no step port, and the ring free-runs as described above.

Test Plan:
- Reset then free-run with opcode=ADD, zero=0:
  - phase sequences 0..7 repeatedly.
  - ld_ir=1 only in phases 2 and 3.
  - rd=1 in phases 1, 2, 3, 5, 6, 7; ld_ac=1 only in phase 7.
  - instr_count=3 after 24 clocks.
- opcode=SKZ: with zero=1, inc_pc=1 in both phase 4 and phase 6. With zero=0, inc_pc=1 only in phase 4. ld_ac is never 1.
- opcode=STO: data_e=1 in phases 6 and 7; wr=1 only in phase 7; rd=0 in phases 5–7.
- opcode=JMP: ld_pc=1 in phases 6 and 7; inc_pc=1 only in phase 4.
- opcode=HLT:
  - halt=1 in phase 4, then stays 1 for 20+ clocks with every other strobe 0.
  - instr_count is incremented once, then frozen.
  - Asserting rst returns phase=0, halt=0, instr_count=0.
- rst asserted in phase 6 with opcode=STO: the next cycle shows phase=0, sel=1, wr=0, data_e=0. With CPU_SEQ_STEP_EN, phase then holds at 0 until step=1, and a 1-cycle step pulse produces exactly one 8-phase pass.
